// File: rtl/mem_bus_if_pkg.sv
// Shared codes for the memory bus adapter: access sizes, FSM states, size helpers.
// No latency: types, constants and pure functions only.
// No backpressure: nothing here is clocked.
package mem_bus_if_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } bus_state_t;

    localparam int SIZE_BYTE  = 1;
    localparam int SIZE_HALF  = 2;
    localparam int SIZE_WORD  = 4;
    localparam int SIZE_DWORD = 8;

    function automatic int size_bytes(input mem_size_t sz);
        case (sz)
            SZ_BYTE: return SIZE_BYTE;
            SZ_HALF: return SIZE_HALF;
            SZ_WORD: return SIZE_WORD;
            default: return SIZE_DWORD;
        endcase
    endfunction

    // A double access can never be served by a 32-bit bus, whatever the address.
    function automatic logic misaligned(input mem_size_t sz, input logic [2:0] addr_lo,
                                        input logic wide64);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return |addr_lo[1:0];
            default: return !wide64 || (|addr_lo);
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_if_lane_align.sv
// Little-endian lane steering: byteenable, lane-shifted store data, extracted/extended load data.
// Latency: purely combinational.
// No backpressure: caller decides when the outputs are used.
// Ports: size/offset/sign_ext/raw in; byteenable, wdata (raw placed on lanes),
//        rdata (raw lanes at offset moved down to bit 0 and extended) out.
module mem_bus_if_lane_align
    import mem_bus_if_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BYTES = DATA_W / 8,
    localparam int OFF_W = $clog2(BYTES)
) (
    input  logic [1:0]        size,
    input  logic [OFF_W-1:0]  offset,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] raw,
    output logic [BYTES-1:0]  byteenable,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    mem_size_t         sz;
    logic [BYTES-1:0]  size_mask;   // low-aligned lanes covered by the access
    logic [DATA_W-1:0] lane_mask;   // size_mask expanded to bits
    logic [DATA_W-1:0] shifted;
    logic              sign_bit;

    assign sz = mem_size_t'(size);

    always_comb begin
        size_mask = '0;
        lane_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            size_mask[i]         = (i < size_bytes(sz));
            lane_mask[i*8 +: 8]  = {8{size_mask[i]}};
        end
    end

    assign byteenable = size_mask << offset;
    assign wdata      = (raw & lane_mask) << {offset, 3'b000};
    assign shifted    = raw >> {offset, 3'b000};

    // Doubles fill the whole bus, so the mask leaves nothing to extend.
    always_comb begin
        sign_bit = 1'b0;
        case (sz)
            SZ_BYTE: sign_bit = shifted[7];
            SZ_HALF: sign_bit = shifted[15];
            SZ_WORD: sign_bit = shifted[31];
            default: sign_bit = 1'b0;
        endcase
    end

    assign rdata = (shifted & lane_mask) | ({DATA_W{sign_ext & sign_bit}} & ~lane_mask);

endmodule

// File: rtl/mem_bus_if.sv
// Avalon-MM master adapter: one load/store at a time with lane steering, stall hold and timeout.
// Latency: strobe one cycle after accept, response one cycle after the non-stalled strobe cycle.
// Backpressure: req_ready_o only in IDLE; bus signals held stable while avm_waitrequest_i is high.
// Ports: req_* request side (valid/ready), resp_* one-cycle completion, avm_* Avalon-MM master.
module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 0
) (
    input  logic                  clk,
    input  logic                  reset_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_W-1:0]     resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  busy_o,
    output logic [ADDR_W-1:0]     avm_address_o,
    output logic                  avm_read_o,
    output logic                  avm_write_o,
    input  logic                  avm_waitrequest_i,
    output logic [DATA_W-1:0]     avm_writedata_o,
    output logic [DATA_W/8-1:0]   avm_byteenable_o,
    input  logic [DATA_W-1:0]     avm_readdata_i
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    // Timeout fires on the stalled cycle that would bring the count to MAX_WAIT.
    localparam logic [CNT_W-1:0] WAIT_LAST = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

    bus_state_t        state, state_nxt;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [OFF_W-1:0]  off_q;
    logic              err_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [BYTES-1:0]  be_q;

    logic              idle, strobe, accept, mis, done, timeout;
    logic [1:0]        la_size;
    logic [OFF_W-1:0]  la_off;
    logic              la_sign;
    logic [DATA_W-1:0] la_raw;
    logic [BYTES-1:0]  la_be;
    logic [DATA_W-1:0] la_wdata;
    logic [DATA_W-1:0] la_rdata;

    assign idle    = (state == IDLE);
    assign strobe  = (state == READ) || (state == WRITE);
    assign accept  = idle && req_valid_i;
    assign mis     = misaligned(mem_size_t'(req_size_i), req_addr_i[2:0], DATA_W == 64);
    assign done    = strobe && !avm_waitrequest_i;
    assign timeout = (MAX_WAIT > 0) && strobe && avm_waitrequest_i && (wait_cnt >= WAIT_LAST);

    // One aligner serves both directions: in IDLE it steers the incoming store,
    // during the bus cycle it extracts the load from the registered request.
    assign la_size = idle ? req_size_i                : size_q;
    assign la_off  = idle ? req_addr_i[OFF_W-1:0]     : off_q;
    assign la_sign = idle ? req_signed_i              : signed_q;
    assign la_raw  = idle ? req_wdata_i               : avm_readdata_i;

    mem_bus_if_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .size       (la_size),
        .offset     (la_off),
        .sign_ext   (la_sign),
        .raw        (la_raw),
        .byteenable (la_be),
        .wdata      (la_wdata),
        .rdata      (la_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    if (mis)              state_nxt = RESP;
                    else if (req_write_i) state_nxt = WRITE;
                    else                  state_nxt = READ;
                end
            end
            READ, WRITE: begin
                if (done || timeout) state_nxt = RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; strobes fall with the asynchronous reset.
    always_comb begin
        req_ready_o  = idle;
        busy_o       = !idle;
        avm_read_o   = (state == READ);
        avm_write_o  = (state == WRITE);
        resp_valid_o = (state == RESP);
        resp_err_o   = (state == RESP) && err_q;
    end

    // Request registers, read capture and wait counter
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            size_q   <= '0;
            signed_q <= 1'b0;
            off_q    <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else if (accept) begin
            size_q   <= req_size_i;
            signed_q <= req_signed_i;
            off_q    <= req_addr_i[OFF_W-1:0];
            addr_q   <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            be_q     <= la_be;
            wdata_q  <= req_write_i ? la_wdata : '0;
            rdata_q  <= '0;
            err_q    <= mis;
            wait_cnt <= '0;
        end else if (strobe) begin
            if (done && (state == READ)) rdata_q <= la_rdata;
            if (timeout)                 err_q   <= 1'b1;
            if (avm_waitrequest_i && (wait_cnt != '1)) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign avm_address_o    = addr_q;
    assign avm_byteenable_o = be_q;
    assign avm_writedata_o  = wdata_q;
    assign resp_rdata_o     = rdata_q;

endmodule

// File: tb/tb_mem_bus_if.sv
module tb_mem_bus_if;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;              // 0: 32-bit instance, 1: 64-bit instance
    logic        req_valid32 = 1'b0, req_valid64 = 1'b0;
    logic        req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        wait_req = 1'b0;
    logic [63:0] bus_rdata = '0;

    logic        rdy32, rv32, err32, busy32, rd32, wr32;
    logic [31:0] rdat32, addr32, wdat32;
    logic [3:0]  be32;
    logic        rdy64, rv64, err64, busy64, rd64, wr64;
    logic [63:0] rdat64, wdat64;
    logic [31:0] addr64;
    logic [7:0]  be64;

    logic        o_ready, o_rv, o_err, o_busy, o_read, o_write;
    logic [63:0] o_rdata, o_wdata;
    logic [31:0] o_addr;
    logic [7:0]  o_be;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_bus_if #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut32 (
        .clk(clk), .reset_n_i(reset_n),
        .req_valid_i(req_valid32), .req_ready_o(rdy32), .req_write_i(req_write),
        .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata[31:0]),
        .resp_valid_o(rv32), .resp_rdata_o(rdat32), .resp_err_o(err32), .busy_o(busy32),
        .avm_address_o(addr32), .avm_read_o(rd32), .avm_write_o(wr32),
        .avm_waitrequest_i(wait_req), .avm_writedata_o(wdat32), .avm_byteenable_o(be32),
        .avm_readdata_i(bus_rdata[31:0])
    );

    mem_bus_if #(.ADDR_W(32), .DATA_W(64), .MAX_WAIT(MAXW)) dut64 (
        .clk(clk), .reset_n_i(reset_n),
        .req_valid_i(req_valid64), .req_ready_o(rdy64), .req_write_i(req_write),
        .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .resp_valid_o(rv64), .resp_rdata_o(rdat64), .resp_err_o(err64), .busy_o(busy64),
        .avm_address_o(addr64), .avm_read_o(rd64), .avm_write_o(wr64),
        .avm_waitrequest_i(wait_req), .avm_writedata_o(wdat64), .avm_byteenable_o(be64),
        .avm_readdata_i(bus_rdata)
    );

    always_comb begin
        if (sel) begin
            o_ready = rdy64; o_rv = rv64; o_err = err64; o_busy = busy64;
            o_read = rd64; o_write = wr64; o_rdata = rdat64; o_wdata = wdat64;
            o_addr = addr64; o_be = be64;
        end else begin
            o_ready = rdy32; o_rv = rv32; o_err = err32; o_busy = busy32;
            o_read = rd32; o_write = wr32; o_rdata = {32'b0, rdat32}; o_wdata = {32'b0, wdat32};
            o_addr = addr32; o_be = {4'b0, be32};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model: byte-by-byte lane placement, little-endian.
    function automatic void model(input bit is64, input bit wr, input logic [1:0] sz,
                                  input bit sg, input logic [31:0] addr, input logic [63:0] wd,
                                  input logic [63:0] rd, input int waits,
                                  output bit mis, output int strobes, output bit err,
                                  output logic [31:0] e_addr, output logic [7:0] e_be,
                                  output logic [63:0] e_wd, output logic [63:0] e_rd);
        int nb, bytes, off;
        nb     = 1 << sz;
        bytes  = is64 ? 8 : 4;
        off    = int'(addr % bytes);
        mis    = ((addr % nb) != 0) || (nb > bytes);
        e_addr = addr - off;
        e_be   = '0;
        e_wd   = '0;
        e_rd   = '0;
        for (int i = 0; i < nb; i++) begin
            if (off + i < bytes) begin
                e_be[off+i]           = 1'b1;
                e_wd[8*(off+i) +: 8]  = wd[8*i +: 8];
                e_rd[8*i +: 8]        = rd[8*(off+i) +: 8];
            end
        end
        if (sg && nb < bytes && e_rd[8*nb-1])
            for (int j = nb; j < bytes; j++) e_rd[8*j +: 8] = 8'hFF;
        if (mis) begin
            err = 1'b1; strobes = 0; e_rd = '0;
        end else if (waits >= MAXW) begin
            err = 1'b1; strobes = MAXW; e_rd = '0;
        end else begin
            err = 1'b0; strobes = waits + 1;
            if (wr) e_rd = '0;
        end
    endfunction

    task automatic do_txn(input bit is64, input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                          input int waits, output logic [63:0] got_rdata,
                          output logic [7:0] got_be, output logic [63:0] got_wdata);
        bit mis, err;
        int strobes;
        logic [31:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wd, e_rd;
        model(is64, wr, sz, sg, addr, wd, rd, waits, mis, strobes, err, e_addr, e_be, e_wd, e_rd);
        got_be = '0;
        got_wdata = '0;
        @(negedge clk);
        sel = is64;
        wait_req = 1'b0;
        #1;
        chk("ready_before_req", {63'b0, o_ready}, 64'd1);
        req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        req_valid32 = !is64; req_valid64 = is64;
        @(posedge clk);
        #1;
        req_valid32 = 1'b0; req_valid64 = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = {$urandom, $urandom};
        for (int k = 1; k <= strobes; k++) begin
            @(negedge clk);
            wait_req  = (k <= waits);
            bus_rdata = (k <= waits) ? {$urandom, $urandom} : rd;
            #1;
            chk("strobe_read",  {63'b0, o_read},  {63'b0, !wr});
            chk("strobe_write", {63'b0, o_write}, {63'b0, wr});
            chk("bus_address",  {32'b0, o_addr},  {32'b0, e_addr});
            chk("byteenable",   {56'b0, o_be},    {56'b0, e_be});
            if (wr) chk("writedata", o_wdata, e_wd);
            chk("busy_in_xfer", {62'b0, o_busy, o_rv}, {62'b0, 1'b1, 1'b0});
            got_be = o_be;
            got_wdata = o_wdata;
        end
        @(negedge clk);
        wait_req = 1'b0;
        #1;
        chk("resp_valid", {63'b0, o_rv}, 64'd1);
        chk("resp_err",   {63'b0, o_err}, {63'b0, err});
        chk("resp_rdata", o_rdata, e_rd);
        chk("no_strobe_in_resp", {62'b0, o_read, o_write}, 64'd0);
        chk("not_ready_in_resp", {63'b0, o_ready}, 64'd0);
        got_rdata = o_rdata;
        @(negedge clk);
        #1;
        chk("resp_one_cycle", {63'b0, o_rv}, 64'd0);
        chk("ready_after_resp", {62'b0, o_ready, o_busy}, {62'b0, 1'b1, 1'b0});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] g_rd, g_wd;
        logic [7:0]  g_be;

        // Reset state of both instances
        #3;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_ready_busy", {62'b0, o_ready, o_busy}, {62'b0, 1'b1, 1'b0});
            chk("rst_strobes",    {62'b0, o_read, o_write}, 64'd0);
            chk("rst_resp",       {62'b0, o_rv, o_err}, 64'd0);
            chk("rst_addr",       {32'b0, o_addr}, 64'd0);
            chk("rst_be_wdata",   o_wdata | {56'b0, o_be}, 64'd0);
            chk("rst_rdata",      o_rdata, 64'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Signed byte load, top lane
        do_txn(0, 0, 2'd0, 1, 32'h0000_1003, 64'd0, 64'h8000_0000_80AB_CD12, 0, g_rd, g_be, g_wd);
        chk("t1_rdata", g_rd, 64'h0000_0000_FFFF_FF80);
        chk("t1_be",    {56'b0, g_be}, 64'h8);
        // Unsigned halfword load
        do_txn(0, 0, 2'd1, 0, 32'h0000_1002, 64'd0, 64'h0000_0000_8001_7777, 0, g_rd, g_be, g_wd);
        chk("t2_rdata", g_rd, 64'h0000_0000_0000_8001);
        chk("t2_be",    {56'b0, g_be}, 64'hC);
        // Byte store with three stall cycles
        do_txn(0, 1, 2'd0, 0, 32'h0000_2001, 64'h0000_0000_1234_565A, 64'd0, 3, g_rd, g_be, g_wd);
        chk("t3_wdata", g_wd, 64'h0000_5A00);
        chk("t3_be",    {56'b0, g_be}, 64'h2);
        chk("t3_rdata", g_rd, 64'd0);
        // Misaligned word load
        do_txn(0, 0, 2'd2, 0, 32'h0000_1002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, g_rd, g_be, g_wd);
        // Timeout with waitrequest stuck
        do_txn(0, 0, 2'd2, 0, 32'h0000_1000, 64'd0, 64'h1111_2222_3333_4444, 20, g_rd, g_be, g_wd);
        // Double on 32-bit bus is always an error
        do_txn(0, 0, 2'd3, 0, 32'h0000_0008, 64'd0, 64'd0, 0, g_rd, g_be, g_wd);
        // 64-bit double and signed word
        do_txn(1, 0, 2'd3, 1, 32'h0000_0008, 64'd0, 64'h8000_0000_0000_0001, 0, g_rd, g_be, g_wd);
        chk("t6a_rdata", g_rd, 64'h8000_0000_0000_0001);
        chk("t6a_be",    {56'b0, g_be}, 64'hFF);
        do_txn(1, 0, 2'd2, 1, 32'h0000_0004, 64'd0, 64'h8000_0000_1234_5678, 1, g_rd, g_be, g_wd);
        chk("t6b_rdata", g_rd, 64'hFFFF_FFFF_8000_0000);
        chk("t6b_be",    {56'b0, g_be}, 64'hF0);

        // Randomized traffic on both widths
        for (int n = 0; n < 80; n++) begin
            bit is64, wr, sg;
            logic [1:0]  sz;
            logic [31:0] addr;
            int waits;
            is64  = 1'($urandom);
            wr    = 1'($urandom);
            sg    = 1'($urandom);
            sz    = 2'($urandom);
            addr  = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 1);
            waits = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            do_txn(is64, wr, sz, sg, addr, {$urandom, $urandom}, {$urandom, $urandom}, waits,
                   g_rd, g_be, g_wd);
        end

        // Reset during a stalled 64-bit read
        @(negedge clk);
        sel = 1'b1;
        req_write = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 32'h40;
        req_valid64 = 1'b1;
        wait_req = 1'b1;
        @(posedge clk);
        #1;
        req_valid64 = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_strobe_before", {63'b0, o_read}, 64'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_strobe_drop", {62'b0, o_read, o_rv}, 64'd0);
        chk("rst_mid_ready",       {63'b0, o_ready}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        wait_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_resp", {62'b0, o_rv, o_read}, 64'd0);
            chk("post_rst_ready",   {63'b0, o_ready}, 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
Parametrised Avalon-MM master adapter between the multi-cycle core's control path and the memory bus.
- Accepts one load/store request at a time: byte, half, word, or double (double only at 64-bit width).
- Generates byteenable and lane-shifted writedata, holds the bus through waitrequest stalls, and returns sign- or zero-extended read data.
- Flags misaligned accesses and bus timeouts.
- Replaces the fixed 4'b1111 byteenable, no-stall bus handling in the CPU top level.

Parameters:
ADDR_W, 32, address width in bits.
DATA_W, 32, bus data width; legal values 32 or 64; BYTES = DATA_W/8.
MAX_WAIT, 0, waitrequest cycles tolerated before a timeout error; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
reset_n_i  in  1  asynchronous, active-low reset.
req_valid_i  in  1  request present.
req_ready_o  out  1  adapter idle, request accepted this cycle if req_valid_i=1.
req_write_i  in  1  1 = store, 0 = load.
req_size_i  in  2  mem_size_t: SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3.
req_signed_i  in  1  load result is sign-extended when 1, zero-extended when 0.
req_addr_i  in  ADDR_W  byte address.
req_wdata_i  in  DATA_W  store data, right-aligned.
resp_valid_o  out  1  one-cycle completion pulse.
resp_rdata_o  out  DATA_W  extended load data; 0 for stores and errors.
resp_err_o  out  1  qualified by resp_valid_o; misaligned access or timeout.
busy_o  out  1  inverse of req_ready_o.
avm_address_o  out  ADDR_W  address with the low log2(BYTES) bits forced to 0.
avm_read_o  out  1  Avalon read strobe.
avm_write_o  out  1  Avalon write strobe.
avm_waitrequest_i  in  1  slave stall.
avm_writedata_o  out  DATA_W  lane-positioned store data.
avm_byteenable_o  out  BYTES  active byte lanes.
avm_readdata_i  in  DATA_W  valid in the cycle the strobe is high and waitrequest is low.

Behaviour:
- Reset (asynchronous, active-low) forces these values:
  - state IDLE;
  - req_ready_o=1; busy_o=0;
  - avm_read_o, avm_write_o, resp_valid_o and resp_err_o all 0;
  - avm_address_o, avm_writedata_o, avm_byteenable_o and resp_rdata_o all 0;
  - wait counter 0.
- FSM states:
  - IDLE: req_ready_o=1. On req_valid_i the request is registered. If misaligned, go to RESP with err=1 and issue no bus cycle. Otherwise go to READ or WRITE.
  - READ / WRITE: the strobe is high. Address, byteenable and writedata come from registers and stay stable while avm_waitrequest_i=1.
    - When waitrequest=0, capture readdata (loads only), drop the strobe, go to RESP.
    - If MAX_WAIT>0 and the wait count reaches MAX_WAIT, drop the strobe, go to RESP with err=1.
  - RESP: resp_valid_o=1 for exactly one cycle, then go to IDLE. No request is accepted in RESP.
- Latency:
  - Request accepted at edge T; strobe high in cycle T+1.
  - Zero-wait access: resp_valid_o in cycle T+2; next request can be accepted at T+3.
  - Each waitrequest cycle adds one cycle.
- Misalignment rules:
  - HALF requires addr[0]=0.
  - WORD requires addr[1:0]=0.
  - DWORD requires addr[2:0]=0 and DATA_W=64; DWORD with DATA_W=32 is always an error.
- Lanes are little-endian; offset = addr mod BYTES.
  - byteenable: BYTE = 1<<offset; HALF = 2'b11<<offset; WORD = 4'hF<<offset; DWORD = all ones.
  - writedata = req_wdata_i masked to the access size, shifted left by 8*offset; unused lanes are 0.
- Load result: the addressed lanes are shifted down to bit 0, then extended to DATA_W per req_signed_i. DWORD results are not extended.
- Stores complete with resp_rdata_o=0.
- Timeout error: resp_rdata_o=0.
- Wait counter clears on entering READ/WRITE. It saturates and does not wrap.
- Reset in mid-transfer: strobes drop asynchronously and no response is issued. The requester must discard the in-flight request.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package codes:
  - mem_size_t enum;
  - bus_state_t enum (IDLE, READ, WRITE, RESP);
  - SIZE_* byte-count constants.
- Sub-module lane_align (combinational):
  - inputs: size, offset, signed flag, raw data;
  - outputs: byteenable, shifted writedata, extracted/extended read data.
- mem_bus_if holds the FSM, request registers and wait counter.

Test Plan:
1. Signed byte load, DATA_W=32:
   - Stimulus: LB signed at 0x0000_1003, waitrequest=0, readdata 0x80AB_CD12.
   - Response: avm_address 0x0000_1000, byteenable 4'b1000, resp_rdata 0xFFFF_FF80, resp_valid at T+2.
2. Unsigned halfword load:
   - Stimulus: LHU at 0x0000_1002, readdata 0x8001_7777.
   - Response: byteenable 4'b1100, resp_rdata 0x0000_8001, err=0.
3. Byte store with stall:
   - Stimulus: SB at 0x0000_2001, wdata 0x1234_565A, waitrequest high for 3 cycles.
   - Response: address 0x0000_2000, byteenable 4'b0010, writedata 0x0000_5A00, all held stable for 4 strobe cycles; resp_valid at T+5 with rdata 0.
4. Misaligned word load:
   - Stimulus: LW at 0x0000_1002.
   - Response: avm_read never asserts; resp_valid with err=1 at T+1.
5. Timeout, MAX_WAIT=4:
   - Stimulus: read with waitrequest stuck high.
   - Response: strobe high for exactly 4 cycles, then resp_valid with err=1 and rdata 0.
6. DATA_W=64 accesses and reset:
   - LD at 0x0000_0008, readdata 0x8000_0000_0000_0001: byteenable 8'hFF, rdata passed unchanged.
   - LW signed at 0x0000_0004, readdata 0x8000_0000_1234_5678: byteenable 8'hF0, rdata 0xFFFF_FFFF_8000_0000.
   - reset_n_i low during a stalled read: strobe 0 immediately, no resp_valid; req_ready_o=1 after release.
